ozy_req_sequencer: RTL and testbench

- Request front-end that sits directly upstream of the team's single-port strobe-driven RAM (addr / we / Type / data_in / data_out, write when Type=1, read when Type=0, operation on rising edge of we).
- Accepts read/write requests over a valid/ready handshake and buffers them in a small FIFO.
- Converts each request into a clean setup/strobe/hold sequence on the RAM pins, returns read data or range errors over a valid/ready response port.
- Rejects out-of-range addresses before they reach the RAM.

---
 rtl/ozy_req_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ozy_req_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ozy_req_sequencer.sv
// Request front-end for the strobe-driven single-port RAM: buffers requests,
// range-checks them and sequences setup/strobe/hold, returning read data.
module ozy_req_sequencer #(
  parameter int word_size     = 21,
  parameter int word_quantity = 33,
  parameter int fifo_depth    = 4,
  localparam int AW = $clog2(word_quantity)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_type,
  input  logic [AW-1:0]        req_addr,
  input  logic [word_size-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [word_size-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic                 mem_type,
  output logic [word_size-1:0] mem_wdata,
  input  logic [word_size-1:0] mem_rdata,
  output logic                 busy
);

  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int EW = 1 + AW + word_size;
  localparam logic [AW:0] WQ = (AW+1)'(word_quantity);
  localparam logic [PW:0] DEPTH = (PW+1)'(fifo_depth);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [EW-1:0] fifo_q [fifo_depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic push;
  logic pop;

  logic                 head_type;
  logic [AW-1:0]        head_addr;
  logic [word_size-1:0] head_wdata;

  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_type_q, mem_type_d;
  logic [word_size-1:0] mem_wdata_q, mem_wdata_d;

  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [word_size-1:0] rsp_data_q, rsp_data_d;

  assign {head_type, head_addr, head_wdata} = fifo_q[rd_ptr_q];

  assign req_ready = (count_q != DEPTH);
  assign push      = rst_n && req_valid && req_ready;

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_type  = mem_type_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);

  // Storage is not reset; the count register alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {req_type, req_addr, req_wdata};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_type_d  = mem_type_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = '0;
    end

    unique case (state_q)
      IDLE: begin
        // A held response blocks pops so the consumer back-pressures the queue.
        if (count_q != '0 && !rsp_valid_q) begin
          pop = 1'b1;
          if ({1'b0, head_addr} >= WQ) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d     = SETUP;
            mem_addr_d  = head_addr;
            mem_type_d  = head_type;
            mem_wdata_d = head_wdata;
          end
        end
      end
      SETUP: begin
        mem_we_d = 1'b1;
        state_d  = STROBE;
      end
      STROBE: begin
        state_d = HOLD;
      end
      HOLD: begin
        state_d = IDLE;
        if (!mem_type_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_type_q  <= 1'b0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_type_q  <= mem_type_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_ozy_req_sequencer.sv
// Bench for ozy_req_sequencer: directed scenarios plus random traffic,
// compared every cycle against a time-stamped transaction model.
module tb_ozy_req_sequencer;

  localparam int WS = 21;
  localparam int WQ = 33;
  localparam int D  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_type = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [WS-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic [WS-1:0] mem_rdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [WS-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_type;
  logic [WS-1:0] mem_wdata;
  logic          busy;

  ozy_req_sequencer #(
    .word_size    (WS),
    .word_quantity(WQ),
    .fifo_depth   (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_type (req_type),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_type (mem_type),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          t;
    logic [AW-1:0] a;
    logic [WS-1:0] d;
  } req_t;

  int tests = 0;
  int fails = 0;

  // Model: request queue, cycles elapsed since the last in-range pop,
  // held response and last RAM pin values.
  req_t          m_q[$];
  int            since = -1;
  logic          m_rv = 1'b0, m_re = 1'b0, m_mt = 1'b0;
  logic [WS-1:0] m_rd = '0, m_mw = '0;
  logic [AW-1:0] m_ma = '0;
  logic [WS-1:0] ram_m  [64];
  logic [WS-1:0] dev_ram[64];
  bit            acc, hs, dopop;
  req_t          e;

  logic [WS:0] rlog[$];
  logic        stype[$];
  int          strobes = 0;
  int          ncyc = 0, last_strobe = -1;
  int          rd_strobe_cyc = 0, rsp_rise_cyc = 0;
  logic        prev_we = 1'b0, prev_rv = 1'b0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [WS:0] lg(input int i);
    if (i < rlog.size()) return rlog[i];
    return 'x;
  endfunction

  always @(posedge mem_we) begin
    if (rst_n) begin
      strobes++;
      stype.push_back(mem_type);
      if (mem_type) dev_ram[mem_addr] = mem_wdata;
      else mem_rdata = dev_ram[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      since = -1;
      m_rv = 0; m_re = 0; m_rd = '0;
      m_ma = '0; m_mt = 0; m_mw = '0;
    end else begin
      acc   = req_valid && (m_q.size() < D);
      hs    = m_rv && rsp_ready;
      dopop = (since < 0) && (m_q.size() > 0) && !m_rv;
      if (hs) begin
        m_rv = 0; m_re = 0; m_rd = '0;
      end
      if (since == 1 && m_mt) ram_m[m_ma] = m_mw;
      if (since == 3) begin
        if (!m_mt) begin
          m_rv = 1; m_re = 0; m_rd = ram_m[m_ma];
        end
        since = -1;
      end else if (since > 0) begin
        since++;
      end
      if (dopop) begin
        e = m_q.pop_front();
        if (e.a >= WQ) begin
          m_rv = 1; m_re = 1; m_rd = '0;
        end else begin
          since = 1;
          m_ma = e.a; m_mt = e.t; m_mw = e.d;
        end
      end
      if (acc) m_q.push_back('{req_type, req_addr, req_wdata});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, m_q.size() < D);
      chk("busy", busy, since > 0 || m_q.size() > 0);
      chk("mem_we", mem_we, since == 2);
      chk("mem_addr", mem_addr, m_ma);
      chk("mem_type", mem_type, m_mt);
      chk("mem_wdata", mem_wdata, m_mw);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_err", rsp_err, m_re);
      chk("rsp_data", rsp_data, m_rd);
      ncyc++;
      if (!rst_n) last_strobe = -1;
      if (mem_we && !prev_we) begin
        if (last_strobe >= 0)
          chk("strobe_gap_ge4", (ncyc - last_strobe) >= 4, 1);
        last_strobe = ncyc;
        if (!mem_type) rd_strobe_cyc = ncyc;
      end
      if (rsp_valid && !prev_rv) rsp_rise_cyc = ncyc;
      if (rst_n && rsp_valid && rsp_ready) rlog.push_back({rsp_err, rsp_data});
      prev_we = mem_we;
      prev_rv = rsp_valid;
    end
  end

  task automatic send(input logic t, input logic [AW-1:0] a,
                      input logic [WS-1:0] d);
    bit ok = 0;
    req_valid = 1; req_type = t; req_addr = a; req_wdata = d;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #2;
    end
    req_valid = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: addr %0d never accepted, required accept", a);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = !busy && !rsp_valid;
    end
    @(posedge clk); #2;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL idle_timeout: busy=%0b rsp_valid=%0b, required 0/0",
               busy, rsp_valid);
    end
  endtask

  logic [WS-1:0] sd[8];
  int            s0;
  bit            seen;
  logic [31:0]   v;

  initial begin
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dev_ram[i] = v[WS-1:0];
      ram_m[i]   = v[WS-1:0];
    end
    rst_n = 0;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #2;

    rsp_ready = 1;
    rlog.delete(); stype.delete(); s0 = strobes;
    send(1, 6'd5, 21'h1ABCD);
    send(0, 6'd5, '0);
    wait_idle(50);
    chk("t1_strobes", strobes - s0, 2);
    chk("t1_type0", stype.size() > 0 ? stype[0] : 1'bx, 1);
    chk("t1_type1", stype.size() > 1 ? stype[1] : 1'bx, 0);
    chk("t1_nrsp", rlog.size(), 1);
    chk("t1_rsp", lg(0), {1'b0, 21'h1ABCD});
    chk("t1_latency", rsp_rise_cyc - rd_strobe_cyc, 2);

    rlog.delete();
    send(1, 6'd0, 21'h1FFFFF);
    send(1, 6'd32, 21'h000000);
    send(0, 6'd0, '0);
    send(0, 6'd32, '0);
    wait_idle(80);
    chk("bnd_nrsp", rlog.size(), 2);
    chk("bnd_rsp0", lg(0), {1'b0, 21'h1FFFFF});
    chk("bnd_rsp1", lg(1), {1'b0, 21'h000000});

    rlog.delete(); s0 = strobes;
    send(0, 6'd33, '0);
    send(1, 6'd63, 21'h12345);
    wait_idle(50);
    chk("oor_strobes", strobes - s0, 0);
    chk("oor_nrsp", rlog.size(), 2);
    chk("oor_rsp0", lg(0), {1'b1, 21'h0});
    chk("oor_rsp1", lg(1), {1'b1, 21'h0});

    rlog.delete();
    rsp_ready = 0;
    send(0, 6'd5, '0);
    send(0, 6'd0, '0);
    send(0, 6'd32, '0);
    send(0, 6'd5, '0);
    send(0, 6'd0, '0);
    @(negedge clk);
    chk("bp_req_ready", req_ready, 0);
    repeat (8) @(negedge clk);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data", rsp_data, 21'h1ABCD);
    repeat (5) @(negedge clk);
    chk("bp_rsp_hold", rsp_data, 21'h1ABCD);
    @(posedge clk); #2;
    rsp_ready = 1;
    wait_idle(100);
    chk("bp_nrsp", rlog.size(), 5);
    chk("bp_rsp0", lg(0), {1'b0, 21'h1ABCD});
    chk("bp_rsp1", lg(1), {1'b0, 21'h1FFFFF});
    chk("bp_rsp2", lg(2), {1'b0, 21'h000000});
    chk("bp_rsp3", lg(3), {1'b0, 21'h1ABCD});
    chk("bp_rsp4", lg(4), {1'b0, 21'h1FFFFF});
    @(negedge clk);
    chk("bp_req_ready_back", req_ready, 1);
    @(posedge clk); #2;

    send(1, 6'd7, 21'h0F0F0);
    send(0, 6'd5, '0);
    send(0, 6'd0, '0);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = mem_we;
    end
    chk("mid_strobe_seen", seen, 1);
    rst_n = 0;
    s0 = strobes;
    @(negedge clk);
    chk("mid_mem_we", mem_we, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_req_ready", req_ready, 1);
    @(posedge clk); #2;
    rst_n = 1;
    repeat (20) @(posedge clk);
    #2;
    chk("mid_no_strobes", strobes - s0, 0);
    chk("mid_write_kept", dev_ram[7], 21'h0F0F0);

    rlog.delete();
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      sd[i] = v[WS-1:0];
      send(1, AW'(10 + i), sd[i]);
      send(0, AW'(10 + i), '0);
    end
    wait_idle(100);
    chk("str_nrsp", rlog.size(), 8);
    for (int i = 0; i < 8; i++) chk("str_rsp", lg(i), {1'b0, sd[i]});

    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom % 3) != 0;
      req_type  = 1'($urandom % 2);
      req_addr  = ($urandom % 4 == 0) ? AW'($urandom_range(0, 63))
                                      : AW'($urandom_range(0, 32));
      v = $urandom;
      req_wdata = v[WS-1:0];
      rsp_ready = ($urandom % 4) != 0;
      rst_n     = ($urandom % 200) != 0;
      @(posedge clk); #2;
    end
    req_valid = 0;
    rst_n = 1;
    rsp_ready = 1;
    wait_idle(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
